sha3_block_padder: RTL and testbench



---
 rtl/sha3_block_padder_if.sv | 27 ++
 rtl/sha3_block_padder.sv | 116 +++++++++++
 tb/tb_sha3_block_padder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sha3_block_padder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha3_block_padder_if                                                        |
// | Word-in / block-out handshake bundle of the SHA3 block padder.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface sha3_block_padder_if;
  logic [31:0]  in;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack;

  modport master (
    output in, in_ready, is_last, byte_num, f_ack,
    input  buffer_full, out, out_ready
  );

  modport slave (
    input  in, in_ready, is_last, byte_num, f_ack,
    output buffer_full, out, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/sha3_block_padder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sha3_block_padder                                                           |
// | Packs 32-bit message words into 576-bit rate blocks with SHA3 padding.      |
// | Define KECCAK_LEGACY_PAD_EN for original Keccak domain byte 0x01.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module sha3_block_padder (
  input  logic              clk,
  input  logic              reset,
  sha3_block_padder_if.slave bus
);
  localparam int WORD_W     = 32;
  localparam int RATE_WORDS = 18;
  localparam int BLOCK_W    = WORD_W * RATE_WORDS;

  localparam logic [4:0]        COUNT_FULL = 5'(RATE_WORDS);
  localparam logic [4:0]        COUNT_LAST = 5'(RATE_WORDS - 1);
  localparam logic [WORD_W-1:0] TERMINATOR = 32'h00000080;
`ifdef KECCAK_LEGACY_PAD_EN
  localparam logic [7:0]        DOMAIN     = 8'h01;
`else
  localparam logic [7:0]        DOMAIN     = 8'h06;
`endif

  typedef enum logic [1:0] {
    ABSORB = 2'd0,
    PAD    = 2'd1,
    FINAL  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [BLOCK_W-1:0] block;
  logic [4:0]         count;
  logic               full;
  logic               busy;
  logic               accept;
  logic               ack;
  logic               last_slot;
  logic               load;
  logic [WORD_W-1:0]  load_word;
  logic [WORD_W-1:0]  pad_word;

  assign full      = (count == COUNT_FULL);
  assign last_slot = (count == COUNT_LAST);
  assign busy      = full | (state != ABSORB);
  assign accept    = bus.in_ready & ~busy;
  assign ack       = bus.f_ack & full;

  assign bus.buffer_full = busy;
  assign bus.out_ready   = full;
  assign bus.out         = block;

  // Domain byte lands directly after the valid, left-aligned message bytes.
  always_comb begin
    case (bus.byte_num)
      2'd0:    pad_word = {DOMAIN, 24'h000000};
      2'd1:    pad_word = {bus.in[31:24], DOMAIN, 16'h0000};
      2'd2:    pad_word = {bus.in[31:16], DOMAIN, 8'h00};
      default: pad_word = {bus.in[31:8], DOMAIN};
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_word  = '0;
    case (state)
      ABSORB: begin
        if (accept) begin
          load = 1'b1;
          if (bus.is_last) begin
            load_word  = pad_word | (last_slot ? TERMINATOR : '0);
            state_next = last_slot ? FINAL : PAD;
          end else begin
            load_word = bus.in;
          end
        end
      end
      PAD: begin
        load      = 1'b1;
        load_word = last_slot ? TERMINATOR : '0;
        if (last_slot) begin
          state_next = FINAL;
        end
      end
      FINAL: begin
        if (ack) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = DONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ABSORB;
      block <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        block <= {block[BLOCK_W-WORD_W-1:0], load_word};
        count <= count + 5'd1;
      end else if (ack) begin
        count <= '0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_sha3_block_padder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sha3_block_padder                                                        |
// | Randomized self-checking bench against a byte-level pad10*1 model.          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_sha3_block_padder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha3_block_padder_if bus();

  sha3_block_padder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef KECCAK_LEGACY_PAD_EN
  localparam logic [7:0] DOMAIN = 8'h01;
`else
  localparam logic [7:0] DOMAIN = 8'h06;
`endif

  int checks   = 0;
  int failures = 0;

  byte unsigned msg[$];
  logic [575:0] exp_blk[$];

  task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: message bytes, domain byte, zero fill to 72-byte multiple, 0x80 in last byte.
  task automatic build_expected();
    byte unsigned p[$];
    logic [575:0] b;
    p = msg;
    p.push_back(DOMAIN);
    while (p.size() % 72 != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    exp_blk.delete();
    for (int k = 0; k < p.size() / 72; k++) begin
      b = '0;
      for (int i = 0; i < 72; i++) b = {b[567:0], p[72*k+i]};
      exp_blk.push_back(b);
    end
  endtask

  // Invalid trailing bytes of the final word carry random junk.
  function automatic logic [31:0] msg_word(int w);
    logic [31:0] v;
    v = $urandom;
    for (int i = 0; i < 4; i++)
      if (4*w + i < msg.size()) v[31-8*i -: 8] = msg[4*w+i];
    return v;
  endfunction

  task automatic do_reset();
    reset        = 1'b1;
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    bus.f_ack    = 1'b0;
    bus.in       = '0;
    bus.byte_num = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run_message();
    int nwords, wi, blk, pos, last_pos, last_edge, cyc, ack_wait;
    bit pend, pend_last, seen, in_pad, pad_checked, just_acked;
    build_expected();
    nwords = msg.size() / 4 + 1;
    do_reset();
    check("reset_out", bus.out, '0);
    check("reset_out_ready", 576'(bus.out_ready), 576'(0));
    check("reset_buffer_full", 576'(bus.buffer_full), 576'(0));
    wi = 0; blk = 0; pos = 0; last_pos = 0; last_edge = 0; cyc = 0; ack_wait = 0;
    pend = 0; pend_last = 0; seen = 0; in_pad = 0; pad_checked = 0; just_acked = 0;
    while (blk < exp_blk.size() && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (pend) begin
        wi++; pos++; last_pos = pos; last_edge = cyc;
        if (pend_last) in_pad = 1;
        pend = 0;
      end
      if (just_acked) begin
        just_acked = 0;
        check("ack_drops_ready", 576'(bus.out_ready), 576'(0));
        check("ack_frees_buffer", 576'(bus.buffer_full), 576'(0));
      end
      bus.f_ack = 1'b0;
      if (bus.out_ready) begin
        if (!seen) begin
          seen = 1;
          check($sformatf("blk%0d_data", blk), bus.out, exp_blk[blk]);
          check($sformatf("blk%0d_latency", blk), 576'(cyc - last_edge), 576'(18 - last_pos));
          check("full_while_ready", 576'(bus.buffer_full), 576'(1));
          ack_wait = $urandom_range(0, 3);
        end
        if (ack_wait == 0) begin
          bus.f_ack = 1'b1;
          blk++; seen = 0; pos = 0;
          just_acked = 1;
        end else begin
          ack_wait--;
        end
      end else begin
        if (in_pad && !pad_checked) begin
          pad_checked = 1;
          check("full_in_pad", 576'(bus.buffer_full), 576'(1));
        end
        bus.f_ack = ($urandom_range(0, 7) == 0);
      end
      if (wi < nwords) begin
        bus.in_ready = ($urandom_range(0, 3) != 0);
        bus.in       = msg_word(wi);
        bus.is_last  = (wi == nwords - 1);
        bus.byte_num = 2'(msg.size() % 4);
      end else begin
        bus.in_ready = 1'($urandom_range(0, 1));
        bus.in       = $urandom;
        bus.is_last  = 1'($urandom_range(0, 1));
        bus.byte_num = 2'($urandom);
      end
      if (wi < nwords && bus.in_ready && !bus.buffer_full) begin
        pend      = 1;
        pend_last = bus.is_last;
      end
    end
    check("all_blocks_seen", 576'(blk), 576'(exp_blk.size()));
    @(posedge clk); #1;
    bus.f_ack = 1'b0;
    check("done_out_ready", 576'(bus.out_ready), 576'(0));
    check("done_buffer_full", 576'(bus.buffer_full), 576'(1));
    check("done_out_hold", bus.out, exp_blk[exp_blk.size()-1]);
    bus.in_ready = 1'b1;
    bus.is_last  = 1'b0;
    bus.in       = $urandom;
    repeat (3) @(posedge clk);
    #1;
    check("done_ignores_input", 576'(bus.buffer_full), 576'(1));
    check("done_out_stable", bus.out, exp_blk[exp_blk.size()-1]);
    bus.in_ready = 1'b0;
  endtask

  task automatic reset_mid_pad();
    msg.delete();
    repeat (10) msg.push_back(8'($urandom));
    do_reset();
    for (int w = 0; w < 3; w++) begin
      bus.in_ready = 1'b1;
      bus.in       = msg_word(w);
      bus.is_last  = (w == 2);
      bus.byte_num = 2'd2;
      @(posedge clk); #1;
    end
    bus.in_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midpad_busy", 576'(bus.buffer_full), 576'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    check("midpad_reset_out", bus.out, '0);
    check("midpad_reset_ready", 576'(bus.out_ready), 576'(0));
    check("midpad_reset_full", 576'(bus.buffer_full), 576'(0));
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_ready = 1'b0;
    bus.is_last  = 1'b0;
    bus.f_ack    = 1'b0;
    bus.in       = '0;
    bus.byte_num = '0;

    msg.delete();
    run_message();

    msg.delete();
    msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    run_message();

    msg.delete();
    repeat (68) msg.push_back(8'($urandom));
    msg.push_back(8'hAA); msg.push_back(8'hBB); msg.push_back(8'hCC);
    run_message();

    msg.delete();
    for (int i = 0; i < 72; i++) msg.push_back(8'(i));
    run_message();

    reset_mid_pad();

    repeat (6) begin
      msg.delete();
      repeat ($urandom_range(0, 220)) msg.push_back(8'($urandom));
      run_message();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
